// File: rtl/interval_timer_arbiter_if.sv
// Handshake and shared-counter bundle between requesters, the arbiter and the external counter.
interface interval_timer_arbiter_if;
    logic [1:0] req;
    logic [7:0] start0;
    logic [7:0] start1;
    logic [1:0] gnt;
    logic [1:0] done;
    logic       busy;
    logic       cnt_rst;
    logic       cnt_load;
    logic       cnt_en;
    logic [7:0] cnt_data;
    logic [7:0] cnt_q;

    modport slave (
        input  req, start0, start1, cnt_q,
        output gnt, done, busy, cnt_rst, cnt_load, cnt_en, cnt_data
    );

    modport master (
        output req, start0, start1, cnt_q,
        input  gnt, done, busy, cnt_rst, cnt_load, cnt_en, cnt_data
    );
endinterface

// File: rtl/interval_timer_arbiter.sv
// Round-robin arbiter that runs one timed interval at a time on a shared 8-bit up-counter.
// Define INTERVAL_TIMER_ARBITER_ABORT_EN to add the abort input that cancels a running interval.
module interval_timer_arbiter #(
    parameter logic [7:0] TERM = 8'hFF
) (
    input logic clk,
    input logic rst,
`ifdef INTERVAL_TIMER_ARBITER_ABORT_EN
    input logic abort,
`endif
    interval_timer_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t     r_state;
    logic [1:0] r_gnt;
    logic [1:0] r_done;
    logic       r_busy;
    logic       r_cnt_load;
    logic [7:0] r_cnt_data;
    logic       r_last;

    logic [1:0] w_win;
    logic [7:0] w_win_start;
    logic       w_at_term;
    logic       w_abort;

`ifdef INTERVAL_TIMER_ARBITER_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // r_last = 1 means requester 1 was served most recently, so requester 0 wins a tie.
    always_comb begin
        w_win = 2'b00;
        if (bus.req == 2'b11) begin
            w_win = r_last ? 2'b01 : 2'b10;
        end else if (bus.req[0]) begin
            w_win = 2'b01;
        end else if (bus.req[1]) begin
            w_win = 2'b10;
        end
    end

    assign w_win_start = w_win[1] ? bus.start1 : bus.start0;
    assign w_at_term   = (bus.cnt_q == TERM);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_gnt      <= 2'b00;
            r_done     <= 2'b00;
            r_busy     <= 1'b0;
            r_cnt_load <= 1'b0;
            r_cnt_data <= 8'h00;
            r_last     <= 1'b1;
        end else begin
            r_done     <= 2'b00;
            r_cnt_load <= 1'b0;
            r_cnt_data <= 8'h00;
            case (r_state)
                IDLE: begin
                    if (|bus.req) begin
                        r_state    <= LOAD;
                        r_gnt      <= w_win;
                        r_busy     <= 1'b1;
                        r_cnt_load <= 1'b1;
                        r_cnt_data <= w_win_start;
                    end
                end
                LOAD: begin
                    if (w_abort) begin
                        r_state <= IDLE;
                        r_gnt   <= 2'b00;
                        r_busy  <= 1'b0;
                        r_last  <= r_gnt[1];
                    end else begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    // A cancelled interval still counts as a turn for the pointer.
                    if (w_abort) begin
                        r_state <= IDLE;
                        r_gnt   <= 2'b00;
                        r_busy  <= 1'b0;
                        r_last  <= r_gnt[1];
                    end else if (w_at_term) begin
                        r_state <= DONE;
                        r_done  <= r_gnt;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_gnt   <= 2'b00;
                    r_busy  <= 1'b0;
                    r_last  <= r_gnt[1];
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt   <= 2'b00;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt      = r_gnt;
    assign bus.done     = r_done;
    assign bus.busy     = r_busy;
    assign bus.cnt_rst  = rst;
    assign bus.cnt_load = r_cnt_load;
    assign bus.cnt_data = r_cnt_data;
    assign bus.cnt_en   = (r_state == RUN) && !w_at_term;

endmodule

// File: tb/tb_interval_timer_arbiter.sv
// Bench for interval_timer_arbiter: two instances (TERM=FF and TERM=02) each driving a modelled counter.
module tb_interval_timer_arbiter;

    typedef struct packed {
        logic [1:0] val;
        int         cyc;
    } ev_t;

    logic clk;
    logic rst;
    logic abort_a;
    logic abort_b;
    int   cyc;
    int   checks;
    int   failures;
    int   en_a;
    ev_t  exp_a[$];
    ev_t  obs_a[$];
    ev_t  exp_b[$];
    ev_t  obs_b[$];

    interval_timer_arbiter_if ifa ();
    interval_timer_arbiter_if ifb ();

    interval_timer_arbiter #(.TERM(8'hFF)) dut_a (
        .clk   (clk),
        .rst   (rst),
`ifdef INTERVAL_TIMER_ARBITER_ABORT_EN
        .abort (abort_a),
`endif
        .bus   (ifa)
    );

    interval_timer_arbiter #(.TERM(8'h02)) dut_b (
        .clk   (clk),
        .rst   (rst),
`ifdef INTERVAL_TIMER_ARBITER_ABORT_EN
        .abort (abort_b),
`endif
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Shared counters: priority rst > load > en, wrapping modulo 256.
    always_ff @(posedge clk) begin
        if (ifa.cnt_rst)       ifa.cnt_q <= 8'h00;
        else if (ifa.cnt_load) ifa.cnt_q <= ifa.cnt_data;
        else if (ifa.cnt_en)   ifa.cnt_q <= ifa.cnt_q + 8'h01;
    end

    always_ff @(posedge clk) begin
        if (ifb.cnt_rst)       ifb.cnt_q <= 8'h00;
        else if (ifb.cnt_load) ifb.cnt_q <= ifb.cnt_data;
        else if (ifb.cnt_en)   ifb.cnt_q <= ifb.cnt_q + 8'h01;
    end

    always @(negedge clk) begin
        if (ifa.done != 2'b00) obs_a.push_back(ev_t'{ifa.done, cyc});
        if (ifb.done != 2'b00) obs_b.push_back(ev_t'{ifb.done, cyc});
        if (ifa.cnt_en === 1'b1) en_a = en_a + 1;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (ifa.cnt_rst !== 1'b1) begin failures++; $display("FAIL reset_cnt_rst got=%b exp=1", ifa.cnt_rst); end
        checks++; if (ifa.gnt !== 2'b00) begin failures++; $display("FAIL reset_gnt got=%b exp=00", ifa.gnt); end
        checks++; if (ifa.done !== 2'b00) begin failures++; $display("FAIL reset_done got=%b exp=00", ifa.done); end
        checks++; if (ifa.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", ifa.busy); end
        checks++; if (ifa.cnt_load !== 1'b0 || ifa.cnt_en !== 1'b0) begin failures++; $display("FAIL reset_cnt_ctl got=%b%b exp=00", ifa.cnt_load, ifa.cnt_en); end
        checks++; if (ifa.cnt_data !== 8'h00) begin failures++; $display("FAIL reset_cnt_data got=%h exp=00", ifa.cnt_data); end
        checks++; if (ifb.gnt !== 2'b00 || ifb.busy !== 1'b0) begin failures++; $display("FAIL reset_b got=%b/%b exp=00/0", ifb.gnt, ifb.busy); end
        rst = 1'b0;
        #1;
        checks++; if (ifa.cnt_rst !== 1'b0) begin failures++; $display("FAIL release_cnt_rst got=%b exp=0", ifa.cnt_rst); end
        tick();
    endtask

    task automatic test_basic();
        int  n;
        ev_t e;
        ev_t o;
        ifa.start0 = 8'hFC;
        ifa.req    = 2'b01;
        en_a       = 0;
        n          = cyc + 1;
        exp_a.push_back(ev_t'{2'b01, n + 5});
        tick();
        checks++; if (ifa.gnt !== 2'b01) begin failures++; $display("FAIL basic_gnt got=%b exp=01", ifa.gnt); end
        checks++; if (ifa.cnt_load !== 1'b1 || ifa.cnt_data !== 8'hFC) begin failures++; $display("FAIL basic_load got=%b/%h exp=1/fc", ifa.cnt_load, ifa.cnt_data); end
        checks++; if (ifa.busy !== 1'b1 || ifa.cnt_en !== 1'b0) begin failures++; $display("FAIL basic_busy_en got=%b/%b exp=1/0", ifa.busy, ifa.cnt_en); end
        tick();
        checks++; if (ifa.cnt_load !== 1'b0 || ifa.cnt_data !== 8'h00 || ifa.cnt_en !== 1'b1) begin failures++; $display("FAIL basic_run got=%b/%h/%b exp=0/00/1", ifa.cnt_load, ifa.cnt_data, ifa.cnt_en); end
        for (int t = 0; t < 50 && obs_a.size() == 0; t++) tick();
        ifa.req = 2'b00;
        tick();
        checks++; if (ifa.busy !== 1'b0 || ifa.gnt !== 2'b00 || cyc != n + 6) begin failures++; $display("FAIL basic_idle got=%b/%b@%0d exp=0/00@%0d", ifa.busy, ifa.gnt, cyc, n + 6); end
        checks++; if (en_a != 3) begin failures++; $display("FAIL basic_en_cycles got=%0d exp=3", en_a); end
        while (exp_a.size() > 0) begin
            e = exp_a.pop_front();
            checks++;
            if (obs_a.size() == 0) begin
                failures++; $display("FAIL basic_done got=none exp=%b@%0d", e.val, e.cyc);
            end else begin
                o = obs_a.pop_front();
                if (o !== e) begin failures++; $display("FAIL basic_done got=%b@%0d exp=%b@%0d", o.val, o.cyc, e.val, e.cyc); end
            end
        end
    endtask

    task automatic test_round_robin_back_to_back();
        int         n;
        ev_t        e;
        ev_t        o;
        logic [1:0] gh [9];
        logic       bh [9];
        rst = 1'b1;
        tick();
        rst = 1'b0;
        obs_a.delete();
        ifa.start0 = 8'hFE;
        ifa.start1 = 8'hFE;
        ifa.req    = 2'b11;
        n          = cyc + 1;
        exp_a.push_back(ev_t'{2'b01, n + 3});
        exp_a.push_back(ev_t'{2'b10, n + 8});
        for (int k = 0; k < 9; k++) begin
            tick();
            gh[k] = ifa.gnt;
            bh[k] = ifa.busy;
        end
        ifa.req = 2'b00;
        tick();
        checks++; if (gh[0] !== 2'b01) begin failures++; $display("FAIL rr_first_gnt got=%b exp=01", gh[0]); end
        checks++; if (gh[5] !== 2'b10) begin failures++; $display("FAIL rr_second_gnt got=%b exp=10", gh[5]); end
        checks++; if (bh[3] !== 1'b1 || bh[4] !== 1'b0 || bh[5] !== 1'b1) begin failures++; $display("FAIL rr_idle_gap got=%b%b%b exp=101", bh[3], bh[4], bh[5]); end
        checks++; if (gh[4] !== 2'b00) begin failures++; $display("FAIL rr_gap_gnt got=%b exp=00", gh[4]); end
        while (exp_a.size() > 0) begin
            e = exp_a.pop_front();
            checks++;
            if (obs_a.size() == 0) begin
                failures++; $display("FAIL rr_done got=none exp=%b@%0d", e.val, e.cyc);
            end else begin
                o = obs_a.pop_front();
                if (o !== e) begin failures++; $display("FAIL rr_done got=%b@%0d exp=%b@%0d", o.val, o.cyc, e.val, e.cyc); end
            end
        end
        checks++; if (obs_a.size() != 0) begin failures++; $display("FAIL rr_extra_done got=%0d exp=0", obs_a.size()); end
    endtask

    task automatic test_start_eq_term();
        int  n;
        ev_t e;
        ev_t o;
        ifa.start1 = 8'hFF;
        ifa.req    = 2'b10;
        en_a       = 0;
        n          = cyc + 1;
        exp_a.push_back(ev_t'{2'b10, n + 2});
        for (int t = 0; t < 20 && obs_a.size() == 0; t++) tick();
        ifa.req = 2'b00;
        tick();
        checks++; if (en_a != 0) begin failures++; $display("FAIL term_en_cycles got=%0d exp=0", en_a); end
        while (exp_a.size() > 0) begin
            e = exp_a.pop_front();
            checks++;
            if (obs_a.size() == 0) begin
                failures++; $display("FAIL term_done got=none exp=%b@%0d", e.val, e.cyc);
            end else begin
                o = obs_a.pop_front();
                if (o !== e) begin failures++; $display("FAIL term_done got=%b@%0d exp=%b@%0d", o.val, o.cyc, e.val, e.cyc); end
            end
        end
    endtask

    task automatic test_drop_req();
        int  n;
        ev_t e;
        ev_t o;
        ifa.start1 = 8'hFD;
        ifa.req    = 2'b10;
        n          = cyc + 1;
        exp_a.push_back(ev_t'{2'b10, n + 4});
        tick();
        checks++; if (ifa.gnt !== 2'b10) begin failures++; $display("FAIL drop_gnt got=%b exp=10", ifa.gnt); end
        ifa.req    = 2'b00;
        ifa.start1 = 8'h00;
        for (int t = 0; t < 20 && obs_a.size() == 0; t++) tick();
        tick();
        while (exp_a.size() > 0) begin
            e = exp_a.pop_front();
            checks++;
            if (obs_a.size() == 0) begin
                failures++; $display("FAIL drop_done got=none exp=%b@%0d", e.val, e.cyc);
            end else begin
                o = obs_a.pop_front();
                if (o !== e) begin failures++; $display("FAIL drop_done got=%b@%0d exp=%b@%0d", o.val, o.cyc, e.val, e.cyc); end
            end
        end
        checks++; if (ifa.busy !== 1'b0) begin failures++; $display("FAIL drop_idle got=%b exp=0", ifa.busy); end
    endtask

    task automatic test_wrap();
        int         n;
        ev_t        e;
        ev_t        o;
        logic [7:0] qh [7];
        logic [7:0] qexp [5];
        qexp = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02};
        ifb.start0 = 8'hFE;
        ifb.req    = 2'b01;
        n          = cyc + 1;
        exp_b.push_back(ev_t'{2'b01, n + 6});
        for (int k = 0; k < 7; k++) begin
            tick();
            qh[k] = ifb.cnt_q;
        end
        ifb.req = 2'b00;
        tick();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (qh[k + 1] !== qexp[k]) begin failures++; $display("FAIL wrap_q%0d got=%h exp=%h", k, qh[k + 1], qexp[k]); end
        end
        while (exp_b.size() > 0) begin
            e = exp_b.pop_front();
            checks++;
            if (obs_b.size() == 0) begin
                failures++; $display("FAIL wrap_done got=none exp=%b@%0d", e.val, e.cyc);
            end else begin
                o = obs_b.pop_front();
                if (o !== e) begin failures++; $display("FAIL wrap_done got=%b@%0d exp=%b@%0d", o.val, o.cyc, e.val, e.cyc); end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit hit;
        hit        = 1'b0;
        ifa.start0 = 8'h00;
        ifa.req    = 2'b01;
        for (int t = 0; t < 300 && !hit; t++) begin
            tick();
            if (ifa.cnt_q === 8'h80 && ifa.busy === 1'b1) hit = 1'b1;
        end
        checks++; if (!hit) begin failures++; $display("FAIL midrst_reach got=%h exp=80", ifa.cnt_q); end
        rst = 1'b1;
        #1;
        checks++; if (ifa.cnt_rst !== 1'b1) begin failures++; $display("FAIL midrst_cnt_rst got=%b exp=1", ifa.cnt_rst); end
        tick();
        checks++; if (ifa.gnt !== 2'b00 || ifa.busy !== 1'b0 || ifa.cnt_en !== 1'b0) begin failures++; $display("FAIL midrst_idle got=%b/%b/%b exp=00/0/0", ifa.gnt, ifa.busy, ifa.cnt_en); end
        rst     = 1'b0;
        ifa.req = 2'b00;
        repeat (4) tick();
        checks++; if (obs_a.size() != 0) begin failures++; $display("FAIL midrst_no_done got=%0d exp=0", obs_a.size()); end
    endtask

`ifdef INTERVAL_TIMER_ARBITER_ABORT_EN
    task automatic test_abort();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        obs_a.delete();
        ifa.start0 = 8'h00;
        ifa.start1 = 8'h00;
        ifa.req    = 2'b11;
        tick();
        checks++; if (ifa.gnt !== 2'b01) begin failures++; $display("FAIL abort_first_gnt got=%b exp=01", ifa.gnt); end
        tick();
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        checks++; if (ifa.gnt !== 2'b00 || ifa.busy !== 1'b0) begin failures++; $display("FAIL abort_idle got=%b/%b exp=00/0", ifa.gnt, ifa.busy); end
        tick();
        checks++; if (ifa.gnt !== 2'b10) begin failures++; $display("FAIL abort_next_tie got=%b exp=10", ifa.gnt); end
        ifa.req = 2'b00;
        rst     = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        checks++; if (obs_a.size() != 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", obs_a.size()); end
    endtask
`endif

    initial begin
        checks     = 0;
        failures   = 0;
        en_a       = 0;
        rst        = 1'b1;
        abort_a    = 1'b0;
        abort_b    = 1'b0;
        ifa.req    = 2'b00;
        ifa.start0 = 8'h00;
        ifa.start1 = 8'h00;
        ifb.req    = 2'b00;
        ifb.start0 = 8'h00;
        ifb.start1 = 8'h00;
        test_reset();
        test_basic();
        test_round_robin_back_to_back();
        test_start_eq_term();
        test_drop_req();
        test_wrap();
        test_reset_mid();
`ifdef INTERVAL_TIMER_ARBITER_ABORT_EN
        test_abort();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench timed out");
    end

endmodule

// File: doc/interval_timer_arbiter.md
INTERVAL_TIMER_ARBITER -- requirements
Module: interval_timer_arbiter

Interface
REQ-001 Parameter TERM, default 8'hFF: terminal count at which an interval ends.
REQ-002 Port clk input 1: single clock; all state updates on its rising edge.
REQ-003 Port rst input 1: reset, synchronous and active-high.
REQ-004 Port req input 2: req[i] high = requester i wants an interval; held until its done pulse.
REQ-005 Port start0 input 8: start value for requester 0.
REQ-006 Port start1 input 8: start value for requester 1.
REQ-007 Port gnt output 2: one-hot grant; at most one bit high.
REQ-008 Port done output 2: one-cycle pulse to the granted requester at interval end.
REQ-009 Port busy output 1: high whenever state is not IDLE.
REQ-010 Port cnt_rst output 1: drives the shared counter's reset.
REQ-011 Port cnt_load output 1: drives the counter's load.
REQ-012 Port cnt_en output 1: drives the counter's enable.
REQ-013 Port cnt_data output 8: drives the counter's load data.
REQ-014 Port cnt_q input 8: counter's current value (8-bit, increments by 1 when enabled; priority rst > load > en).

Function
REQ-015 The FSM SHALL have states IDLE, LOAD, RUN and DONE.
REQ-016 In IDLE with any req bit set, the FSM SHALL pick a winner, register gnt, latch the winner's start value and go to LOAD on the next edge.
REQ-017 Arbitration SHALL be round-robin. With both requesters asserting, the requester not served last wins. A single requester always wins.
REQ-018 In LOAD, cnt_load SHALL be 1 and cnt_data SHALL equal the latched start value for exactly one cycle. The next state SHALL be RUN.
REQ-019 In RUN, cnt_en SHALL be high (combinationally) iff cnt_q != TERM. When cnt_q == TERM, the next state SHALL be DONE.
REQ-020 In DONE, done[g] SHALL be 1 for that single cycle, where g is the granted requester. gnt SHALL clear at the following edge, the last-served pointer SHALL update to g, and the next state SHALL be IDLE.
REQ-021 Latency: if req is sampled in IDLE at edge N, done SHALL be high in the cycle starting at edge N+2+(TERM-start).
REQ-022 If start == TERM, cnt_en SHALL never assert and done SHALL fire at edge N+2.
REQ-023 If start > TERM, the counter SHALL wrap through 8'hFF to 0 and continue until it equals TERM. Arithmetic is modulo 256.
REQ-024 Outside LOAD, cnt_load SHALL be 0 and cnt_data SHALL be 8'h00. Outside RUN, cnt_en SHALL be 0.
REQ-025 Dropping req while granted SHALL be ignored. The interval SHALL still complete and done SHALL still pulse.
REQ-026 req and start changes after the grant SHALL NOT affect the running interval.
REQ-027 A request may be accepted on the first IDLE cycle after DONE. The back-to-back gap SHALL be exactly one IDLE cycle.

Reset
REQ-028 While rst is high, cnt_rst SHALL equal 1; otherwise it SHALL be 0.
REQ-029 On a reset edge, the state SHALL become IDLE and gnt, done, busy, cnt_load and cnt_en SHALL all be 0.
REQ-030 On a reset edge, the pointer SHALL be set so that requester 0 wins the first tie.
REQ-031 Reset mid-interval SHALL abandon the interval with no done pulse.

Configuration
REQ-032 With macro INTERVAL_TIMER_ARBITER_ABORT_EN defined, the block SHALL add port abort input 1.
REQ-033 With the macro defined, abort high in LOAD or RUN SHALL send the FSM to IDLE at the next edge. gnt SHALL clear, no done SHALL pulse, and the pointer SHALL update as if served.
REQ-034 With the macro defined, abort SHALL have no effect in IDLE or DONE.
REQ-035 Without the macro, the abort port and logic SHALL be absent and intervals always complete.

Verification
REQ-036 Stimulus: req=01, start0=8'hFC, TERM=8'hFF. Response: cnt_load at N+1, cnt_en for 3 cycles, done=01 at N+5, busy low at N+6.
REQ-037 Stimulus: req=11 after reset, repeated twice. Response: first gnt=01, then gnt=10. Each done pulses once, and IDLE lasts exactly one cycle between intervals.
REQ-038 Stimulus: start1=8'hFF, req=10. Response: cnt_en never high and done=10 at N+2.
REQ-039 Stimulus: TERM=8'h02, start0=8'hFE. Response: cnt_q sequence FE, FF, 00, 01, 02 and done at N+6.
REQ-040 Stimulus: rst high during RUN with cnt_q=8'h80. Response: cnt_rst=1 in the same cycle, state IDLE and gnt=00 next edge, no done.
REQ-041 Stimulus (ABORT_EN build): abort pulse in RUN. Response: IDLE next edge, no done, and the next tie goes to the other requester.
